// File: rtl/multimode_counter.sv
// ---------------------------------------------------------------------------
// multimode_counter
//   Programmable up/down counter with a prescaler, synchronous load, a
//   programmable terminal limit and four count modes (wrap, saturate,
//   one-shot, ping-pong).  All outputs are registered.
//
// Parameters
//   WIDTH    counter width in bits (>= 2)
//   PRESC_W  prescaler compare width in bits (>= 1)
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous active-low reset
//   en        in   count enable (prescaler and count freeze when low)
//   up        in   direction request, 1 = up (ping-pong samples it at load)
//   load      in   synchronous load strobe, wins over a tick
//   load_val  in   value to load (clamped to limit)
//   limit     in   terminal value, count range is 0..limit
//   mode      in   00 wrap, 01 saturate, 10 one-shot, 11 ping-pong
//   prescale  in   a tick occurs every prescale+1 enabled cycles
//   count     out  current count
//   tc        out  terminal-count pulse, one cycle wide
//   dir       out  effective direction, 1 = up
//   done      out  one-shot complete (level)
// ---------------------------------------------------------------------------
module multimode_counter #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               up,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   limit,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] prescale,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               dir,
  output logic               done
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_PINGPONG = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0]   CNT_ONE = WIDTH'(1);
  localparam logic [PRESC_W-1:0] PC_ONE  = PRESC_W'(1);

  logic [WIDTH-1:0]   count_q, count_d;
  logic [PRESC_W-1:0] pc_q, pc_d;
  logic               tc_q, tc_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;

  mode_e              mode_s;
  logic               dir_eff;
  logic [WIDTH-1:0]   term;
  logic [WIDTH-1:0]   step;
  logic               tick;

  assign mode_s = mode_e'(mode);

  // Outside ping-pong the direction simply follows 'up'; in ping-pong the
  // registered direction is the bounce state.
  assign dir_eff = (mode_s == MODE_PINGPONG) ? dir_q : up;
  assign term    = dir_eff ? limit : '0;
  assign step    = dir_eff ? (count_q + CNT_ONE) : (count_q - CNT_ONE);

  // '>=' rather than '==' so lowering prescale mid-count cannot strand pc
  // above the compare value.
  assign tick = en && !done_q && (pc_q >= prescale);

  always_comb begin
    count_d = count_q;
    pc_d    = pc_q;
    tc_d    = 1'b0;
    dir_d   = dir_eff;
    done_d  = done_q;

    if (load) begin
      count_d = (load_val > limit) ? limit : load_val;
      pc_d    = '0;
      done_d  = 1'b0;
      dir_d   = up;
    end else if (en && !done_q) begin
      if (!tick) begin
        pc_d = pc_q + PC_ONE;
      end else begin
        pc_d = '0;
        if (count_q > limit) begin
          // limit was lowered under the count: clamp silently
          count_d = limit;
        end else begin
          unique case (mode_s)
            MODE_WRAP: begin
              if (count_q == term) begin
                count_d = dir_eff ? '0 : limit;
                tc_d    = 1'b1;
              end else begin
                count_d = step;
              end
            end
            MODE_SAT, MODE_ONESHOT: begin
              if (count_q == term) begin
                // Sitting on the terminal: hold, no repeated pulse.
                if (mode_s == MODE_ONESHOT) done_d = 1'b1;
              end else begin
                count_d = step;
                if (step == term) begin
                  tc_d = 1'b1;
                  if (mode_s == MODE_ONESHOT) done_d = 1'b1;
                end
              end
            end
            MODE_PINGPONG: begin
              if (limit == '0) begin
                // Degenerate range: count stays 0, every tick bounces.
                tc_d  = 1'b1;
                dir_d = ~dir_q;
              end else if (count_q == term) begin
                count_d = dir_q ? (limit - CNT_ONE) : CNT_ONE;
                dir_d   = ~dir_q;
                tc_d    = 1'b1;
              end else begin
                count_d = step;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      pc_q    <= '0;
      tc_q    <= 1'b0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      tc_q    <= tc_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign dir   = dir_q;
  assign done  = done_q;

endmodule

// File: tb/tb_multimode_counter.sv
// ---------------------------------------------------------------------------
// tb_multimode_counter
//   Directed scenarios from the counter's behaviour description plus a long
//   randomized run, all checked against a cycle-level reference model that
//   works on plain integers.
// ---------------------------------------------------------------------------
module tb_multimode_counter;

  localparam int W  = 8;
  localparam int PW = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n, en, up, load;
  logic [W-1:0]  load_val, limit;
  logic [1:0]    mode;
  logic [PW-1:0] prescale;
  logic [W-1:0]  count;
  logic          tc, dir, done;

  always #5 clk = ~clk;

  multimode_counter #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .limit(limit), .mode(mode), .prescale(prescale),
    .count(count), .tc(tc), .dir(dir), .done(done)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  int m_count, m_pc, m_tc, m_dir, m_done;

  // Applies the documented rules for one rising edge using the inputs
  // present at that edge.
  task automatic model_step();
    int lim, t;
    lim = int'(limit);
    if (!rst_n) begin
      m_count = 0; m_pc = 0; m_tc = 0; m_done = 0; m_dir = 1;
      return;
    end
    if (load) begin
      m_count = (int'(load_val) > lim) ? lim : int'(load_val);
      m_pc = 0; m_tc = 0; m_done = 0; m_dir = int'(up);
      return;
    end
    m_tc = 0;
    if (mode != 2'b11) m_dir = int'(up);
    if (!en || m_done != 0) return;
    if (m_pc < int'(prescale)) begin
      m_pc = m_pc + 1;
      return;
    end
    m_pc = 0;
    if (m_count > lim) begin
      m_count = lim;
      return;
    end
    case (mode)
      2'b00: begin
        if (m_dir != 0) begin
          if (m_count == lim) begin m_count = 0; m_tc = 1; end
          else m_count = m_count + 1;
        end else begin
          if (m_count == 0) begin m_count = lim; m_tc = 1; end
          else m_count = m_count - 1;
        end
      end
      2'b01, 2'b10: begin
        t = (m_dir != 0) ? lim : 0;
        if (m_count == t) begin
          if (mode == 2'b10) m_done = 1;
        end else begin
          if (m_dir != 0) m_count = m_count + 1;
          else            m_count = m_count - 1;
          if (m_count == t) begin
            m_tc = 1;
            if (mode == 2'b10) m_done = 1;
          end
        end
      end
      default: begin
        if (lim == 0) begin
          m_tc = 1; m_dir = (m_dir != 0) ? 0 : 1;
        end else if (m_dir != 0) begin
          if (m_count == lim) begin m_count = lim - 1; m_dir = 0; m_tc = 1; end
          else m_count = m_count + 1;
        end else begin
          if (m_count == 0) begin m_count = 1; m_dir = 1; m_tc = 1; end
          else m_count = m_count - 1;
        end
      end
    endcase
  endtask

  function automatic logic [W+2:0] model_vec();
    logic [W-1:0] c;
    c = W'(m_count);
    return {c, m_tc[0], m_dir[0], m_done[0]};
  endfunction

  // ---------------- driver ----------------
  // Advance one edge, update the model from the same inputs, then settle.
  task automatic clk_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic l, input logic [W-1:0] lv, input logic [W-1:0] lim,
                       input logic [1:0] md, input logic u, input logic [PW-1:0] ps,
                       input logic e);
    load = l; load_val = lv; limit = lim; mode = md; up = u; prescale = ps; en = e;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 8'd77, 8'd100, 2'b00, 1'b0, 4'd0, 1'b1);
    clk_step();
    clk_step();
    checks++;
    if ({count, tc, dir, done} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset: got count=%0d tc=%0b dir=%0b done=%0b, need 0/0/1/0", count, tc, dir, done);
    end
    checks++;
    if ({count, tc, dir, done} !== model_vec()) begin
      errors++;
      $display("FAIL reset_model: got %0h need %0h", {count, tc, dir, done}, model_vec());
    end
  endtask

  task automatic test_wrap_up();
    int exp_cnt[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    rst_n = 1'b1;
    drive(1'b0, 8'd0, 8'd5, 2'b00, 1'b1, 4'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      clk_step();
      checks++;
      if (count !== W'(exp_cnt[i]) || tc !== (i == 5)) begin
        errors++;
        $display("FAIL wrap_up[%0d]: got count=%0d tc=%0b, need %0d/%0b", i, count, tc, exp_cnt[i], (i == 5));
      end
      checks++;
      if ({count, tc, dir, done} !== model_vec()) begin
        errors++;
        $display("FAIL wrap_up_model[%0d]: got %0h need %0h", i, {count, tc, dir, done}, model_vec());
      end
    end
  endtask

  task automatic test_wrap_down_en();
    // count after each edge: load, 3 enabled edges, 1 enabled, 4 frozen, 2 enabled
    int exp_cnt[11] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3};
    int exp_tc[11]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    drive(1'b1, 8'd1, 8'd3, 2'b00, 1'b0, 4'd2, 1'b1);
    for (int i = 0; i < 11; i++) begin
      if (i == 1) load = 1'b0;
      en = !(i >= 5 && i <= 8);
      clk_step();
      checks++;
      if (count !== W'(exp_cnt[i]) || tc !== exp_tc[i][0]) begin
        errors++;
        $display("FAIL wrap_down_en[%0d]: got count=%0d tc=%0b, need %0d/%0d", i, count, tc, exp_cnt[i], exp_tc[i]);
      end
      checks++;
      if ({count, tc, dir, done} !== model_vec()) begin
        errors++;
        $display("FAIL wrap_down_en_model[%0d]: got %0h need %0h", i, {count, tc, dir, done}, model_vec());
      end
    end
  endtask

  task automatic test_sat();
    int exp_cnt[9] = '{2, 3, 4, 4, 4, 4, 4, 4, 3};
    int exp_tc[9]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    drive(1'b1, 8'd2, 8'd4, 2'b01, 1'b1, 4'd0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      if (i == 1) load = 1'b0;
      if (i == 8) up = 1'b0;
      clk_step();
      checks++;
      if (count !== W'(exp_cnt[i]) || tc !== exp_tc[i][0]) begin
        errors++;
        $display("FAIL sat[%0d]: got count=%0d tc=%0b, need %0d/%0d", i, count, tc, exp_cnt[i], exp_tc[i]);
      end
      checks++;
      if ({count, tc, dir, done} !== model_vec()) begin
        errors++;
        $display("FAIL sat_model[%0d]: got %0h need %0h", i, {count, tc, dir, done}, model_vec());
      end
    end
  endtask

  task automatic test_oneshot();
    int exp_cnt[8]  = '{253, 254, 255, 255, 255, 255, 0, 1};
    int exp_tc[8]   = '{0, 0, 1, 0, 0, 0, 0, 0};
    int exp_done[8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    drive(1'b1, 8'd253, 8'd255, 2'b10, 1'b1, 4'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      load = (i == 0 || i == 6);
      load_val = (i == 6) ? 8'd0 : 8'd253;
      clk_step();
      checks++;
      if (count !== W'(exp_cnt[i]) || tc !== exp_tc[i][0] || done !== exp_done[i][0]) begin
        errors++;
        $display("FAIL oneshot[%0d]: got count=%0d tc=%0b done=%0b, need %0d/%0d/%0d",
                 i, count, tc, done, exp_cnt[i], exp_tc[i], exp_done[i]);
      end
      checks++;
      if ({count, tc, dir, done} !== model_vec()) begin
        errors++;
        $display("FAIL oneshot_model[%0d]: got %0h need %0h", i, {count, tc, dir, done}, model_vec());
      end
    end
  endtask

  task automatic test_pingpong();
    int exp_cnt[6] = '{1, 2, 1, 0, 1, 2};
    int exp_tc[6]  = '{0, 0, 1, 0, 1, 0};
    int exp_dir[6] = '{1, 1, 0, 0, 1, 1};
    drive(1'b1, 8'd0, 8'd2, 2'b11, 1'b1, 4'd0, 1'b1);
    clk_step();
    load = 1'b0;
    up = 1'b0;  // ping-pong ignores 'up' after the load
    for (int i = 0; i < 6; i++) begin
      clk_step();
      checks++;
      if (count !== W'(exp_cnt[i]) || tc !== exp_tc[i][0] || dir !== exp_dir[i][0]) begin
        errors++;
        $display("FAIL pingpong[%0d]: got count=%0d tc=%0b dir=%0b, need %0d/%0d/%0d",
                 i, count, tc, dir, exp_cnt[i], exp_tc[i], exp_dir[i]);
      end
      checks++;
      if ({count, tc, dir, done} !== model_vec()) begin
        errors++;
        $display("FAIL pingpong_model[%0d]: got %0h need %0h", i, {count, tc, dir, done}, model_vec());
      end
    end
  endtask

  task automatic test_corners();
    logic [W+2:0] exp_v[6];
    // 0: load 10 (wrap up, limit 10)
    // 1: load 4 on an edge that would otherwise wrap with tc
    // 2: load 9 against limit 6 -> clamped
    // 3: load 7 under limit 10
    // 4: limit drops to 2 -> clamp, no tc
    // 5: reset together with load
    exp_v = '{{8'd10, 3'b010}, {8'd4, 3'b010}, {8'd6, 3'b010},
              {8'd7, 3'b010}, {8'd2, 3'b010}, {8'd0, 3'b010}};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(1'b1, 8'd10, 8'd10, 2'b00, 1'b1, 4'd0, 1'b1);
        1: drive(1'b1, 8'd4,  8'd10, 2'b00, 1'b1, 4'd0, 1'b1);
        2: drive(1'b1, 8'd9,  8'd6,  2'b00, 1'b1, 4'd0, 1'b1);
        3: drive(1'b1, 8'd7,  8'd10, 2'b00, 1'b1, 4'd0, 1'b1);
        4: drive(1'b0, 8'd0,  8'd2,  2'b00, 1'b1, 4'd0, 1'b1);
        default: begin
          drive(1'b1, 8'd50, 8'd100, 2'b11, 1'b0, 4'd0, 1'b1);
          rst_n = 1'b0;
        end
      endcase
      clk_step();
      checks++;
      if ({count, tc, dir, done} !== exp_v[i]) begin
        errors++;
        $display("FAIL corner[%0d]: got count=%0d tc=%0b dir=%0b done=%0b, need %0h",
                 i, count, tc, dir, done, exp_v[i]);
      end
      checks++;
      if ({count, tc, dir, done} !== model_vec()) begin
        errors++;
        $display("FAIL corner_model[%0d]: got %0h need %0h", i, {count, tc, dir, done}, model_vec());
      end
    end
    rst_n = 1'b1;
    load  = 1'b0;
  endtask

  task automatic test_random();
    logic [W+2:0] exp_q[$];
    logic [W+2:0] exp;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      load  = ($urandom_range(0, 19) == 0);
      en    = ($urandom_range(0, 3) != 0);
      up    = ($urandom_range(0, 7) != 0) ? up : ~up;
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0)
        limit = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 39) == 0) prescale = 4'($urandom_range(0, 3));
      load_val = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      clk_step();
      exp_q.push_back(model_vec());
      exp = exp_q.pop_front();
      checks++;
      if ({count, tc, dir, done} !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got count=%0d tc=%0b dir=%0b done=%0b, need %0h",
                 i, count, tc, dir, done, exp);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 2'b00, 1'b1, '0, 1'b0);
    test_reset();
    test_wrap_up();
    test_wrap_down_en();
    test_sat();
    test_oneshot();
    test_pingpong();
    test_corners();
    limit = 8'd5;
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
